// File: rtl/conv_unit_mc.sv
// conv_unit_mc -- multi-channel FxF 2-D convolution over a raster pixel stream.
//
// Each iValid cycle delivers one pixel per channel. F-1 line buffers per
// channel and an FxF window register per channel present the full window
// together with the incoming pixel. A free-running 3-stage pipeline then
// forms all C*F*F products (S1), per-channel sums (S2), and the cross-channel
// sum with rounding, saturation and optional ReLU (S3).
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   iValid  in   input pixel vector valid
//   sof     in   start of frame, qualified by iValid; pixel is (row 0, col 0)
//   iData   in   DATA_WIDTH*C, channel ch at [ch*DATA_WIDTH +: DATA_WIDTH]
//   param   in   DATA_WIDTH*F*F*C, weight (ch,ky,kx) at ((ch*F+ky)*F+kx)*DATA_WIDTH
//   oValid  out  one-cycle pulse per completed window, 3 cycles after its input
//   result  out  DATA_WIDTH signed result, held while oValid is low
module conv_unit_mc #(
    parameter int DATA_WIDTH = 16,
    parameter int C          = 3,
    parameter int F          = 3,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int ACC_WIDTH  = 40,
    parameter int SHIFT      = 8,
    parameter int RELU       = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         iValid,
    input  logic                         sof,
    input  logic [DATA_WIDTH*C-1:0]      iData,
    input  logic [DATA_WIDTH*F*F*C-1:0]  param,
    output logic                         oValid,
    output logic [DATA_WIDTH-1:0]        result
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int PW = 2 * DATA_WIDTH;

    localparam logic [ACC_WIDTH:0] RND_ONE = {{ACC_WIDTH{1'b0}}, 1'b1};
    // Half an output LSB; evaluates to zero when SHIFT is zero.
    localparam logic signed [ACC_WIDTH:0] RND = (RND_ONE << SHIFT) >> 1;
    localparam logic signed [ACC_WIDTH:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic [CW-1:0]         col_q, col_d, col_eff;
    logic [RW-1:0]         row_q, row_d, row_eff;
    logic                  v1_q, v1_d, v2_q, v2_d, ovalid_q, ovalid_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;

    logic [DATA_WIDTH-1:0]        lb_q   [C][F-1][IMG_W];
    logic [DATA_WIDTH-1:0]        win_q  [C][F][F];
    logic [DATA_WIDTH-1:0]        win_d  [C][F][F];
    logic signed [PW-1:0]         prod_q [C][F*F];
    logic signed [PW-1:0]         prod_d [C][F*F];
    logic signed [ACC_WIDTH-1:0]  sum_q  [C];
    logic signed [ACC_WIDTH-1:0]  sum_d  [C];
    logic signed [ACC_WIDTH:0]    acc_s, shifted_s;
    logic [DATA_WIDTH-1:0]        sat_s, relu_s;

    // Position of the current pixel: sof forces (0,0) for this pixel.
    always_comb begin
        if (sof) begin
            col_eff = '0;
            row_eff = '0;
        end else begin
            col_eff = col_q;
            row_eff = row_q;
        end
    end

    // Raster counters advance on iValid; wrap of the last row starts the next frame.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (iValid) begin
            if (col_eff == CW'(IMG_W - 1)) begin
                col_d = '0;
                if (row_eff == RW'(IMG_H - 1)) begin
                    row_d = '0;
                end else begin
                    row_d = row_eff + RW'(1);
                end
            end else begin
                col_d = col_eff + CW'(1);
                row_d = row_eff;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

    // Pipeline valid chain; S1 launches when this pixel completes a window.
    always_comb begin
        v1_d     = iValid && (row_eff >= RW'(F - 1)) && (col_eff >= CW'(F - 1));
        v2_d     = v1_q;
        ovalid_d = v2_q;
    end

    // Next window: shift left one column, new right column from line buffers + pixel.
    always_comb begin
        win_d = win_q;
        if (iValid) begin
            for (int ch = 0; ch < C; ch++) begin
                for (int ky = 0; ky < F; ky++) begin
                    for (int kx = 0; kx < F - 1; kx++) begin
                        win_d[ch][ky][kx] = win_q[ch][ky][kx+1];
                    end
                end
                for (int ky = 0; ky < F - 1; ky++) begin
                    win_d[ch][ky][F-1] = lb_q[ch][ky][col_eff];
                end
                win_d[ch][F-1][F-1] = iData[ch*DATA_WIDTH +: DATA_WIDTH];
            end
        end else begin
            win_d = win_q;
        end
    end

    // S1 operands: products are taken from the next window so the current pixel counts.
    always_comb begin
        for (int ch = 0; ch < C; ch++) begin
            for (int ky = 0; ky < F; ky++) begin
                for (int kx = 0; kx < F; kx++) begin
                    prod_d[ch][ky*F+kx] =
                        PW'($signed(win_d[ch][ky][kx])) *
                        PW'($signed(param[((ch*F+ky)*F+kx)*DATA_WIDTH +: DATA_WIDTH]));
                end
            end
        end
    end

    // S2 operands: per-channel sum of sign-extended products.
    always_comb begin
        for (int ch = 0; ch < C; ch++) begin
            sum_d[ch] = '0;
            for (int k = 0; k < F*F; k++) begin
                sum_d[ch] = sum_d[ch] + ACC_WIDTH'(prod_q[ch][k]);
            end
        end
    end

    // S3 operands: cross-channel sum, round-half-up, saturate, optional ReLU.
    always_comb begin
        acc_s = '0;
        for (int ch = 0; ch < C; ch++) begin
            acc_s = acc_s + (ACC_WIDTH+1)'(sum_q[ch]);
        end
        shifted_s = (acc_s + RND) >>> SHIFT;
        if (shifted_s > SAT_MAX) begin
            sat_s = SAT_MAX[DATA_WIDTH-1:0];
        end else if (shifted_s < SAT_MIN) begin
            sat_s = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            sat_s = shifted_s[DATA_WIDTH-1:0];
        end
        if ((RELU != 0) && sat_s[DATA_WIDTH-1]) begin
            relu_s = '0;
        end else begin
            relu_s = sat_s;
        end
        if (v2_q) begin
            result_d = relu_s;
        end else begin
            result_d = result_q;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q    <= '0;
            row_q    <= '0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            ovalid_q <= 1'b0;
            result_q <= '0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            ovalid_q <= ovalid_d;
            result_q <= result_d;
        end
    end

    // Datapath storage; contents are always rewritten before use, so no reset.
    always_ff @(posedge clk) begin
        if (iValid) begin
            for (int ch = 0; ch < C; ch++) begin
                for (int ky = 0; ky < F - 2; ky++) begin
                    lb_q[ch][ky][col_eff] <= lb_q[ch][ky+1][col_eff];
                end
                lb_q[ch][F-2][col_eff] <= iData[ch*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        win_q  <= win_d;
        prod_q <= prod_d;
        sum_q  <= sum_d;
    end

    assign oValid = ovalid_q;
    assign result = result_q;

endmodule
